data_mem_lsu: RTL and testbench

- Parametrised successor of the single-cycle byte memory for the RV32I core's load/store path.
- Word-organised RAM with byte-lane writes and full RV32I load decoding: lb, lh, lw, lbu, lhu, with sign or zero extension.
- Adds a valid/ready request-response handshake, a programmable read latency, misalignment/range/funct3 error reporting, and a post-reset sequential clear sweep.
- Sits between the core's execute stage and memory; one transaction outstanding.

---
 rtl/data_mem_lsu.sv | 198 +++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data RAM for the RV32I load/store path.
//
// Byte-lane stores (sb/sh/sw), RV32I load decode with sign/zero extension
// (lb/lh/lw/lbu/lhu), valid/ready request and response handshakes, a fixed
// programmable read latency, error reporting for misaligned, out-of-range and
// illegal-funct3 accesses, and a sequential clear sweep after every reset.
// One transaction is outstanding at a time.
//
// Ports:
//   clk         rising-edge clock
//   rst_        asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE only)
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32I funct3 of the load/store
//   req_wdata   store data, right-aligned
//   resp_valid  response present
//   resp_ready  consumer accepts the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    request was rejected
module data_mem_lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 8192,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int WORDS   = DEPTH_BYTES / 4;
  localparam int BYTE_AW = $clog2(DEPTH_BYTES);
  localparam int IDX_W   = BYTE_AW - 2;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] clr_cnt;
  logic [2:0]       lat_cnt;
  logic [31:0]      mem [WORDS];

  // Rejects out-of-range addresses, misaligned halves/words and funct3
  // codes that have no meaning for the access direction.
  function automatic logic acc_err(input logic write, input logic [2:0] f3,
                                   input logic [ADDR_WIDTH-1:0] addr);
    logic bad;
    bad = (addr >> BYTE_AW) != '0;
    if (write) begin
      case (f3)
        3'b000:  bad = bad;
        3'b001:  bad = bad | addr[0];
        3'b010:  bad = bad | addr[1] | addr[0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = bad;
        3'b001, 3'b101: bad = bad | addr[0];
        3'b010:         bad = bad | addr[1] | addr[0];
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Little-endian lane extraction plus sign/zero extension.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the right-aligned data lets the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3,
                                             input logic [31:0] wdata);
    case (f3)
      3'b000:  return {4{wdata[7:0]}};
      3'b001:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // ---- p0: request decode, RAM read and write at the acceptance edge ----
  logic             accept_p0;
  logic             err_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic [31:0]      rd_word_p0;

  assign accept_p0  = (state == IDLE) && req_valid;
  assign idx_p0     = req_addr[BYTE_AW-1:2];
  assign lane_p0    = req_addr[1:0];
  assign err_p0     = acc_err(req_write, req_funct3, req_addr);
  assign rd_word_p0 = mem[idx_p0];

  logic             we;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    we      = 1'b0;
    wr_idx  = idx_p0;
    wr_be   = store_be(req_funct3, lane_p0);
    wr_data = store_data(req_funct3, req_wdata);
    if (state == INIT) begin
      we      = 1'b1;
      wr_idx  = clr_cnt;
      wr_be   = 4'b1111;
      wr_data = '0;
    end else if (accept_p0 && req_write && !err_p0) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---- p1: response held from acceptance until the handshake completes ----
  logic [31:0] rdata_p1;
  logic        err_p1;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= INIT;
      clr_cnt  <= '0;
      lat_cnt  <= '0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + IDX_W'(1);
      if (accept_p0) begin
        lat_cnt  <= '0;
        err_p1   <= err_p0;
        rdata_p1 <= (req_write || err_p0) ? '0
                                          : load_ext(rd_word_p0, lane_p0, req_funct3);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  // WAIT lasts RD_LATENCY-1 cycles so resp_valid is sampled high
  // RD_LATENCY edges after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (clr_cnt == IDX_W'(WORDS - 1)) state_nxt = IDLE;
      IDLE: if (req_valid) state_nxt = (RD_LATENCY > 1) ? WAIT : RESP;
      WAIT: if (int'(lat_cnt) >= RD_LATENCY - 2) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_p1;
  assign resp_err   = err_p1;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

  localparam int AW    = 32;
  localparam int DEPTH = 8192;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_funct3;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  data_mem_lsu #(
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DEPTH),
    .RD_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Byte-addressed reference memory.
  logic [7:0] model_mem [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic w, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v = '{w, a, f, wd, er, ee};
    vecs.push_back(v);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endtask

  function automatic logic model_err(input logic w, input logic [31:0] a, input logic [2:0] f);
    if (a >= DEPTH) return 1'b1;
    if (w) return !(f == 0 || (f == 1 && a % 2 == 0) || (f == 2 && a % 4 == 0));
    return !(f == 0 || f == 4 || ((f == 1 || f == 5) && a % 2 == 0) || (f == 2 && a % 4 == 0));
  endfunction

  task automatic model_access(input logic w, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    er = model_err(w, a, f);
    rd = '0;
    if (!er) begin
      n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      if (w) begin
        for (int i = 0; i < n; i++) model_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One complete transaction; called and returns #1 after a rising edge.
  task automatic xact(input string name, input logic w, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    rd = 'x;
    er = 1'bx;
    req_write  = w;
    req_addr   = a;
    req_funct3 = f;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, LAT - 1);
    if (!resp_valid) begin
      resp_ready = 1'b0;
      return;
    end
    rd = resp_rdata;
    er = resp_err;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd, first;
    logic        er, exp_er;
    int          n;
    logic        w;
    logic [31:0] a, wd;
    logic [2:0]  f;

    rst_       = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_funct3 = 3'b000;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", 32'(resp_err), 0);

    // Clear sweep length with a request already waiting.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b010;
    @(negedge clk);
    rst_ = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!req_ready && n < 5000);
    chk("init_cycles", n, DEPTH / 4);
    model_clear();
    xact("lw0_after_init", 1'b0, 32'h0, 3'b010, 32'h0, 0, rd, er);
    chk("lw0_after_init_rdata", rd, 32'h0);
    chk("lw0_after_init_err", 32'(er), 0);

    // Directed vectors.
    addv(1, 32'h10, 3'b010, 32'h80F0A5C3, 32'h0, 0);
    addv(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 0);
    addv(0, 32'h13, 3'b100, 32'h0, 32'h00000080, 0);
    addv(0, 32'h12, 3'b001, 32'h0, 32'hFFFF80F0, 0);
    addv(0, 32'h10, 3'b101, 32'h0, 32'h0000A5C3, 0);
    addv(1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0);
    addv(1, 32'h21, 3'b000, 32'h0000007E, 32'h0, 0);
    addv(0, 32'h20, 3'b010, 32'h0, 32'h11227E44, 0);
    addv(1, 32'h22, 3'b001, 32'h0000BEEF, 32'h0, 0);
    addv(0, 32'h20, 3'b010, 32'h0, 32'hBEEF7E44, 0);
    addv(1, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0);
    addv(0, 32'h102, 3'b010, 32'h0, 32'h0, 1);
    addv(1, 32'h41, 3'b001, 32'h00001234, 32'h0, 1);
    addv(0, 32'h40, 3'b010, 32'h0, 32'hCAFEF00D, 0);
    addv(0, DEPTH, 3'b000, 32'h0, 32'h0, 1);
    addv(0, 32'h0, 3'b011, 32'h0, 32'h0, 1);
    addv(1, 32'h0, 3'b011, 32'h5555AAAA, 32'h0, 1);
    addv(0, 32'h11, 3'b101, 32'h0, 32'h0, 1);
    addv(0, 32'h22, 3'b100, 32'h0, 32'h000000EF, 0);

    foreach (vecs[i]) begin
      xact($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].wd, i % 3, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      model_access(vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].wd, exp_rd, exp_er);
    end

    // Response held with resp_ready low; a competing store must be ignored.
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_latency", n, LAT - 1);
    first = resp_rdata;
    chk("hold_first_rdata", first, 32'h80F0A5C3);
    req_write  = 1'b1;
    req_wdata  = 32'hDEADBEEF;
    req_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), 32'(resp_valid), 1);
      chk($sformatf("hold%0d_rdata", k), resp_rdata, 32'h80F0A5C3);
      chk($sformatf("hold%0d_req_ready", k), 32'(req_ready), 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hold_done_valid", 32'(resp_valid), 0);
    chk("hold_done_ready", 32'(req_ready), 1);
    xact("hold_readback", 1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
    chk("hold_readback_rdata", rd, 32'h80F0A5C3);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 15))
        0:       a = DEPTH + $urandom_range(0, 7);
        1:       a = 32'hFFFFFFF0 + $urandom_range(0, 15);
        2, 3:    a = $urandom_range(0, DEPTH - 1);
        default: a = $urandom_range(0, 63);
      endcase
      model_access(w, a, f, wd, exp_rd, exp_er);
      xact($sformatf("rnd%0d", i), w, a, f, wd, ($urandom_range(0, 3) == 0) ? 2 : 0, rd, er);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_er));
    end

    // Reset while a load waits in the latency pipeline.
    xact("pre_rst_sw", 1'b1, 32'h80, 3'b010, 32'h12345678, 0, rd, er);
    model_access(1'b1, 32'h80, 3'b010, 32'h12345678, exp_rd, exp_er);
    xact("pre_rst_lw", 1'b0, 32'h80, 3'b010, 32'h0, 0, rd, er);
    chk("pre_rst_lw_rdata", rd, 32'h12345678);
    req_write  = 1'b0;
    req_addr   = 32'h80;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_resp_valid", 32'(resp_valid), 0);
    chk("wait_resp_rdata", resp_rdata, 32'h12345678);
    rst_ = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_resp_rdata", resp_rdata, 0);
    chk("midrst_resp_err", 32'(resp_err), 0);
    @(negedge clk);
    rst_ = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!req_ready && n < 5000);
    chk("reinit_cycles", n, DEPTH / 4);
    model_clear();
    xact("post_rst_lw", 1'b0, 32'h80, 3'b010, 32'h0, 0, rd, er);
    chk("post_rst_lw_rdata", rd, 32'h0);
    chk("post_rst_lw_err", 32'(er), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
